// File: rtl/ah_func_pkg.sv
// Shared types and constants for the ah_func stream wrapper.
// Holds the pipeline latency, float constants and a NaN classifier.
package ah_func_pkg;

    localparam int AH_FUNC_LATENCY = 52;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_ZERO = 32'h0000_0000;
    localparam fp32_t FP_QNAN = 32'h7FC0_0000;

    // Any all-ones exponent with a non-zero mantissa is a NaN (quiet or signalling).
    function automatic logic fp32_is_nan(input fp32_t v);
        return (v[30:23] == FP_QNAN[30:23]) && (v[22:0] != 23'd0);
    endfunction

endpackage

// File: rtl/ah_stream_fifo.sv
// First-word-fall-through FIFO with a registered head stage and an occupancy count.
// count covers both the RAM entries and the head register.
module ah_stream_fifo
    import ah_func_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic [AW:0]   count
);

    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE = {{(AW-1){1'b0}}, 1'b1};

    fp32_t           mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     mem_cnt_q, mem_cnt_d;
    logic            head_vld_q, head_vld_d;
    fp32_t           head_q, head_d;
    logic            pop;
    logic            load;

    assign pop  = head_vld_q & rd_ready;
    // Refill the head whenever it is empty or being consumed this cycle.
    assign load = (mem_cnt_q != '0) & (~head_vld_q | rd_ready);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        head_vld_d = head_vld_q;
        head_d     = head_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (load) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            head_vld_d = 1'b1;
            head_d     = mem_q[rd_ptr_q];
        end else if (pop) begin
            head_vld_d = 1'b0;
        end
        case ({wr_en, load})
            2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
            2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
            default: mem_cnt_d = mem_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            head_vld_q <= 1'b0;
            head_q     <= FP_ZERO;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            head_vld_q <= head_vld_d;
            head_q     <= head_d;
        end
    end

    assign rd_valid = head_vld_q;
    assign rd_data  = head_q;
    assign count    = mem_cnt_q + {{AW{1'b0}}, head_vld_q};

endmodule

// File: rtl/ah_func_stream_ctrl.sv
// Valid/ready wrapper around the stall-free ah_func pipeline with credit-based output buffering.
// Optional sticky NaN flag (err_nan/err_clr) enabled by defining AH_FUNC_NAN_FLAG_EN.
module ah_func_stream_ctrl
    import ah_func_pkg::*;
#(
    parameter int LATENCY    = AH_FUNC_LATENCY,
    parameter int FIFO_DEPTH = 64,
    parameter int AW         = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic [31:0] func_dataa,
    output logic [31:0] func_datab,
    input  logic [31:0] func_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
`ifdef AH_FUNC_NAN_FLAG_EN
    ,
    input  logic        err_clr,
    output logic        err_nan
`endif
);

    localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [AW+1:0] CREDITS = (AW+2)'(FIFO_DEPTH);

    logic [LATENCY:0] vld_sr_q, vld_sr_d;
    fp32_t            func_dataa_q, func_dataa_d;
    logic [AW:0]      inflight_q, inflight_d;
    logic [AW:0]      fifo_count;
    logic             fire_in;
    logic             tap;

    // Every accepted sample reserves a FIFO slot up front, so a result can always be captured.
    assign in_ready = ({1'b0, inflight_q} + {1'b0, fifo_count}) < CREDITS;
    assign fire_in  = in_valid & in_ready;
    assign tap      = vld_sr_q[LATENCY];

    always_comb begin
        func_dataa_d = fire_in ? in_data : FP_ZERO;
        vld_sr_d     = {vld_sr_q[LATENCY-1:0], fire_in};
        case ({fire_in, tap})
            2'b10:   inflight_d = inflight_q + CNT_ONE;
            2'b01:   inflight_d = inflight_q - CNT_ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            func_dataa_q <= FP_ZERO;
            vld_sr_q     <= '0;
            inflight_q   <= '0;
        end else begin
            func_dataa_q <= func_dataa_d;
            vld_sr_q     <= vld_sr_d;
            inflight_q   <= inflight_d;
        end
    end

    ah_stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (tap),
        .wr_data  (func_result),
        .rd_ready (out_ready),
        .rd_valid (out_valid),
        .rd_data  (out_data),
        .count    (fifo_count)
    );

    assign func_dataa = func_dataa_q;
    assign func_datab = FP_ZERO;
    assign busy       = (inflight_q != '0) | (fifo_count != '0) | out_valid;

`ifdef AH_FUNC_NAN_FLAG_EN
    logic err_nan_q;

    // Set wins over clear so a NaN landing in the clear cycle is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_nan_q <= 1'b0;
        end else if (tap && fp32_is_nan(func_result)) begin
            err_nan_q <= 1'b1;
        end else if (err_clr) begin
            err_nan_q <= 1'b0;
        end
    end

    assign err_nan = err_nan_q;
`endif

endmodule

// File: tb/tb_ah_func_stream_ctrl.sv
// Scoreboard bench for ah_func_stream_ctrl using an identity delay model for ah_func.
// NaN flag scenario is built only when AH_FUNC_NAN_FLAG_EN is defined.
module tb_ah_func_stream_ctrl;
    import ah_func_pkg::*;

    localparam int LAT   = 52;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [31:0] func_dataa;
    logic [31:0] func_datab;
    logic [31:0] func_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
`ifdef AH_FUNC_NAN_FLAG_EN
    logic        err_clr;
    logic        err_nan;
`endif

    always #5 clk = ~clk;

    ah_func_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .AW(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .func_dataa  (func_dataa),
        .func_datab  (func_datab),
        .func_result (func_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy)
`ifdef AH_FUNC_NAN_FLAG_EN
        ,
        .err_clr     (err_clr),
        .err_nan     (err_nan)
`endif
    );

    // ah_func stand-in: result equals the operand LAT cycles after it was registered; never reset.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= func_dataa;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign func_result = pipe[LAT-1];

    int    n_pass  = 0;
    int    n_total = 0;
    fp32_t exp_q [$];
    int    occ     = 0;
    int    occ_max = 0;
    int    n_pops  = 0;
    logic  hold_q  = 1'b0;
    fp32_t hold_data;

    function automatic fp32_t int_to_fp32(input int v);
        int          msb;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        msb = 0;
        for (int b = 0; b < 31; b++) if (v[b]) msb = b;
        m = 32'(v) << (23 - msb);
        return {1'b0, 8'(127 + msb), m[22:0]};
    endfunction

    // Scoreboard monitor: samples mid-cycle what will happen at the next rising edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_q = 1'b0;
        end else begin
            n_total++;
            if (in_ready !== (occ < DEPTH)) $display("FAIL in_ready_credit: got %b want %b (occ=%0d)", in_ready, occ < DEPTH, occ);
            else n_pass++;
            if (hold_q) begin
                n_total++;
                if (out_valid !== 1'b1 || out_data !== hold_data)
                    $display("FAIL out_hold_stable: got v=%b d=%h want v=1 d=%h", out_valid, out_data, hold_data);
                else n_pass++;
            end
            hold_q    = out_valid & ~out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sb_unexpected: got %h want no output", out_data);
                end else begin
                    fp32_t e;
                    e = exp_q.pop_front();
                    if (out_data !== e) $display("FAIL sb_data: got %h want %h", out_data, e);
                    else n_pass++;
                end
                occ--;
                n_pops++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                occ++;
                if (occ > occ_max) occ_max = occ;
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
`ifdef AH_FUNC_NAN_FLAG_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({out_valid, busy} !== 2'b00 || out_data !== 32'h0 || func_dataa !== 32'h0 || func_datab !== 32'h0)
            $display("FAIL reset_outputs: got v=%b busy=%b d=%h a=%h b=%h want all 0", out_valid, busy, out_data, func_dataa, func_datab);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
`ifdef AH_FUNC_NAN_FLAG_EN
        n_total++;
        if (err_nan !== 1'b0) $display("FAIL reset_err_nan: got %b want 0", err_nan);
        else n_pass++;
`endif
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int first = -1;
        int fall  = -1;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'h0000_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_busy_inflight: got %b want 1", busy);
        else n_pass++;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            if (out_valid && first < 0) begin
                first = k;
                n_total++;
                if (out_data !== 32'h0) $display("FAIL single_data: got %h want 00000000", out_data);
                else n_pass++;
            end
            if (first > 0 && fall < 0 && !busy) fall = k;
        end
        n_total++;
        if (first != LAT + 2) $display("FAIL single_latency: got %0d want %0d", first, LAT + 2);
        else n_pass++;
        n_total++;
        if (fall != first + 1) $display("FAIL single_busy_fall: got %0d want %0d", fall, first + 1);
        else n_pass++;
    endtask

    task automatic test_full_rate();
        int n_out = 0, first_o = -1, last_o = -1, drops = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            in_valid = (c < 100);
            in_data  = int_to_fp32(c + 1);
            @(negedge clk);
            if (c < 100 && !in_ready) drops++;
            if (out_valid) begin
                n_out++;
                if (first_o < 0) first_o = c;
                last_o = c;
            end
        end
        in_valid = 1'b0;
        n_total++;
        if (n_out != 100) $display("FAIL full_rate_count: got %0d want 100", n_out);
        else n_pass++;
        n_total++;
        if (last_o - first_o + 1 != 100) $display("FAIL full_rate_gapless: got span %0d want 100", last_o - first_o + 1);
        else n_pass++;
        n_total++;
        if (drops != 0) $display("FAIL full_rate_in_ready: got %0d low cycles want 0", drops);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0) $display("FAIL full_rate_drain: got %0d pending want 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int pops0;
        int waited = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 32'h4000_0000 + 32'(c);
            @(negedge clk);
            if (in_ready) acc++;
        end
        n_total++;
        if (acc != DEPTH) $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_in_ready_low: got %b want 0", in_ready);
        else n_pass++;
        pops0 = n_pops;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL bp_ready_before_pop: got %b want 0", in_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_after_pop: got %b want 1", in_ready);
        else n_pass++;
        while ((exp_q.size() != 0 || busy) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (n_pops - pops0 != DEPTH || busy) $display("FAIL bp_drain: got %0d pops busy=%b want %0d busy=0", n_pops - pops0, busy, DEPTH);
        else n_pass++;
    endtask

    task automatic test_random();
        int acc = 0, cyc = 0, waited = 0;
        while (acc < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_valid && in_ready) acc++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (acc != 10000) $display("FAIL random_accepts: got %0d want 10000", acc);
        else n_pass++;
        n_total++;
        if (exp_q.size() != 0 || busy) $display("FAIL random_drain: got %0d pending busy=%b want 0 0", exp_q.size(), busy);
        else n_pass++;
        n_total++;
        if (occ_max > DEPTH) $display("FAIL random_occupancy: got %0d want <= %0d", occ_max, DEPTH);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int acc = 0, cyc = 0, seen = 0, waited = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        while (acc < 30 && cyc < 200) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 32'h3000_0001 + 32'(cyc);
            @(negedge clk);
            if (in_ready) acc++;
            cyc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL rst_mid_pre_valid: got %b want 1", out_valid);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        occ = 0;
        n_total++;
        if ({out_valid, busy} !== 2'b00 || out_data !== 32'h0 || func_dataa !== 32'h0 || in_ready !== 1'b1)
            $display("FAIL rst_mid_clear: got v=%b busy=%b d=%h a=%h rdy=%b want 0 0 0 0 1", out_valid, busy, out_data, func_dataa, in_ready);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (out_valid || busy) seen++;
        end
        n_total++;
        if (seen != 0) $display("FAIL rst_mid_ghost: got %0d active cycles want 0", seen);
        else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = 32'h1234_5678;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || busy) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_total++;
        if (exp_q.size() != 0 || busy) $display("FAIL rst_mid_recover: got %0d pending want 0", exp_q.size());
        else n_pass++;
    endtask

`ifdef AH_FUNC_NAN_FLAG_EN
    task automatic test_nan();
        int waited = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; in_data = FP_QNAN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (busy && waited < 200) begin @(posedge clk); #1; waited++; end
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (err_nan !== 1'b1) $display("FAIL nan_set: got %b want 1", err_nan);
        else n_pass++;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        n_total++;
        if (err_nan !== 1'b0) $display("FAIL nan_clear: got %b want 0", err_nan);
        else n_pass++;
        in_valid = 1'b1; in_data = 32'h7F80_0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        waited = 0;
        while (busy && waited < 200) begin @(posedge clk); #1; waited++; end
        n_total++;
        if (err_nan !== 1'b0) $display("FAIL nan_inf_ignored: got %b want 0", err_nan);
        else n_pass++;
    endtask
`endif

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_full_rate();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef AH_FUNC_NAN_FLAG_EN
        test_nan();
`endif
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ah_func_stream_ctrl.md
Name: ah_func_stream_ctrl

Overview:
- Flow-control wrapper that sits directly around ah_func, the fixed-latency stall-free float pipeline computing f(x). It feeds ah_func's dataa input and consumes its result.
- It accepts float samples on a valid/ready stream and drives them into ah_func. A valid bit rides a shift register matched to the pipeline latency.
- Results are captured into an output FIFO and delivered on a valid/ready stream.
- Credit accounting guarantees that no in-flight result is ever dropped, even though ah_func cannot stall.

Parameters:
- LATENCY, 52: cycles from func_dataa register update to the matching func_result. Must equal ah_func's latency.
- FIFO_DEPTH, 64: output FIFO entries. Must be a power of 2 and at least LATENCY+1.
- AW, 6: log2(FIFO_DEPTH).

Ports:
- clk, input, 1: system clock; all state updates on its rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: input sample valid.
- in_ready, output, 1: block can accept a sample this cycle.
- in_data, input, 32: IEEE-754 single input x.
- func_dataa, output, 32: registered operand to ah_func dataa.
- func_datab, output, 32: tied to 32'h00000000.
- func_result, input, 32: ah_func result.
- out_valid, output, 1: out_data holds a result.
- out_ready, input, 1: consumer accepts the result.
- out_data, output, 32: result, in input order.
- busy, output, 1: high while any sample is in flight or the FIFO is non-empty.

Behaviour:
- Reset (async assert, sync release): func_dataa=0, valid shift register=0, inflight=0, FIFO empty, out_valid=0, out_data=0, busy=0.
- Accept: fire_in = in_valid & in_ready.
- in_ready = (inflight + fifo_count) < FIFO_DEPTH. It is combinational from registered counters only and never depends on in_valid or out_ready.
- Issue: on fire_in, func_dataa <= in_data and vld_sr[0] <= 1. Otherwise func_dataa <= 0 (bubble) and vld_sr[0] <= 0.
- vld_sr is LATENCY+1 bits and shifts every cycle. Its tap at index LATENCY marks func_result as valid in that cycle.
- Capture: when the tap is high, func_result is written to the FIFO at the next edge.
- inflight counter: +1 on fire_in, -1 on capture. Both in the same cycle leaves it unchanged.
- Output stage is first-word-fall-through with a registered head. out_valid/out_data update on the edge after the write when the FIFO was empty.
- First out_valid is exactly LATENCY+2 cycles after the accepting edge.
- Pop on out_valid & out_ready. Back-to-back pops and writes sustain 1 sample/cycle.
- Simultaneous capture and pop on a full FIFO is legal. The credit rule guarantees capture into a full FIFO never occurs.
- out_data must hold stable while out_valid & !out_ready.
- busy = (inflight != 0) | (fifo_count != 0) | out_valid.
- Reset mid-operation discards all in-flight and buffered samples. Any results ah_func still emits afterwards are ignored because vld_sr is cleared.
- Pointers are AW-bit and wrap modulo FIFO_DEPTH. Full/empty are resolved by a separate AW+1-bit count.

Optional Feature:
- Macro: AH_FUNC_NAN_FLAG_EN.
- When defined, adds output err_nan (1 bit, reset 0). It is sticky and sets on capture of a result with exponent 8'hFF and non-zero mantissa.
- It also adds input err_clr (1 bit), which clears err_nan synchronously. A set and a clear in the same cycle leaves err_nan set.
- When undefined, neither port exists and there is no NaN logic.

Decomposition:
- Package ah_func_pkg holds:
  - AH_FUNC_LATENCY = 52.
  - Float constants FP_ZERO = 32'h00000000 and FP_QNAN = 32'h7FC00000.
  - typedef fp32_t (32-bit).
- Sub-module ah_stream_fifo(DEPTH, AW) provides the FWFT FIFO with count output.
- The controller instantiates ah_stream_fifo. The bench instantiates ah_func or a delay model outside this block.

Test Plan:
- Single sample: in_data=32'h00000000 with real ah_func → out_data=32'h00000000, out_valid rises exactly 54 cycles after the accept edge; busy falls one cycle after pop.
- Ordering at full rate, with a delay model (result = dataa, LATENCY=52): stream 1..100 (as floats, 1.0=32'h3F800000) with out_ready=1 → 100 results, same order, no gaps after the first, in_ready stays 1.
- Backpressure with the delay model: out_ready=0, in_valid held high → exactly 64 accepts, then in_ready=0. Release out_ready → all 64 returned in order, no loss, in_ready re-asserts after the first pop.
- Random in_valid/out_ready (50%), 10k samples, with the delay model → scoreboard matches in order; FIFO never overflows; inflight+fifo_count never exceeds 64.
- Reset mid-stream after 30 accepts → all outputs 0 immediately; late func_result activity produces no out_valid; a new sample after release returns correctly.
- AH_FUNC_NAN_FLAG_EN with the delay model: input 32'h7FC00000 → err_nan=1 and stays high; err_clr pulse → err_nan=0; input 32'h7F800000 (inf) → err_nan stays 0.
